nibble_demux: RTL and testbench
===============================

NIBBLE_DEMUX -- requirements
Module: nibble_demux

Interface
REQ-001 Parameter DATA_W, default 4, the width of one data word (nibble).
REQ-002 Parameter DEPTH, default 4, the number of entries in each channel buffer; must be a power of two, minimum 2.
REQ-003 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 Port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 Port q, input, DATA_W bits: the incoming data word.
REQ-006 Port q_valid, input, 1 bit: q and q_sel are valid this cycle.
REQ-007 Port q_sel, input, 1 bit: destination of the word; 0 selects channel A, 1 selects channel B.
REQ-008 Port q_ready, output, 1 bit: the selected channel can accept a word.
REQ-009 Port a, output, DATA_W bits: head word of channel A.
REQ-010 Port fa, output, 1 bit: channel A valid (a holds data).
REQ-011 Port a_ready, input, 1 bit: the consumer takes a when fa=1.
REQ-012 Port b, output, DATA_W bits: head word of channel B.
REQ-013 Port fb, output, 1 bit: channel B valid (b holds data).
REQ-014 Port b_ready, input, 1 bit: the consumer takes b when fb=1.
REQ-015 Port a_level, output, $clog2(DEPTH)+1 bits: channel A occupancy.
REQ-016 Port b_level, output, $clog2(DEPTH)+1 bits: channel B occupancy.
REQ-017 Port ovf, output, 1 bit: sticky flag, set when a word was offered to a full channel.

Function
REQ-018 Input handshake: a word is accepted only in a cycle where q_valid=1 and q_ready=1.
REQ-019 q_ready = (q_sel ? !full_B : !full_A); it depends combinationally on q_sel and on registered occupancy only, never on a_ready or b_ready.
REQ-020 An accepted word is pushed into the channel given by q_sel; it is never written to the other channel.
REQ-021 Each channel is a FIFO: words leave in the order they were accepted.
REQ-022 fa = (a_level != 0) and fb = (b_level != 0); a and b show the current head word, registered.
REQ-023 Latency: a word accepted at edge N appears on a/fa (or b/fb) after edge N, i.e. in cycle N+1, when its channel was empty.
REQ-024 A pop occurs when fX=1 and X_ready=1; the next entry is presented in the following cycle.
REQ-025 Simultaneous push and pop on a non-full channel: the level is unchanged and both operations take effect.
REQ-026 Full channel: q_ready=0 for that channel even if it pops in the same cycle; no combinational pass-through.
REQ-027 X_ready=1 while the channel is empty has no effect; the level does not underflow.
REQ-028 Read and write pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
REQ-029 ovf sets in any cycle with q_valid=1 and the selected channel full, and stays set until reset.
REQ-030 Channels A and B operate fully independently; one channel being full never blocks the other.
REQ-031 The contents of a, b and buffer memory are don't-care while the corresponding level is 0.

Reset
REQ-032 While rst=1 at a rising clk edge: both levels and all pointers clear to 0, fa=0, fb=0, ovf=0, a=0, b=0.
REQ-033 A reset asserted mid-transfer discards all buffered words; no pop or push takes effect in that cycle.
REQ-034 q_ready is 1 (the channels are empty) in the first cycle after reset is released.

Structure
REQ-035 Package nibble_demux_pkg holds DATA_W/DEPTH defaults and the typedef enum logic {CH_A=1'b0, CH_B=1'b1} ch_sel_t.
REQ-036 One sub-module, demux_chan_fifo (push, pop, data in/out, level, full, empty), is instantiated twice.
REQ-037 Routing logic, q_ready and ovf live in nibble_demux; there is no logic outside these two modules.

Verification
REQ-038 Reset, then q=4'h4, q_sel=0, q_valid for 1 cycle -> next cycle fa=1, a=4'h4, fb=0, a_level=1.
REQ-039 Push 4'hF, 4'h5 to B and 4'hC to A with a_ready=b_ready=0 -> b_level=2, a_level=1; then b_ready=1 -> b=4'hF, then 4'h5, then fb=0.
REQ-040 Push 4 words to A with a_ready=0 -> q_ready=0 for q_sel=0 while q_ready=1 for q_sel=1; a 5th valid word to A -> ovf=1, a_level stays 4.
REQ-041 A full and a_ready=1 with q_valid=1, q_sel=0 -> no push that cycle, a_level becomes 3.
REQ-042 Half-full A, push and pop together for 10 cycles -> a_level constant, output order matches input across the pointer wrap.
REQ-043 Assert rst with both channels at level 2 -> next cycle fa=fb=0, levels 0, ovf=0, q_ready=1.

Source files
------------

// File: rtl/nibble_demux_pkg.sv
// rtl/nibble_demux_pkg.sv - shared defaults and channel-select type for the nibble demux
package nibble_demux_pkg;

    localparam int DATA_W_DEF = 4;
    localparam int DEPTH_DEF  = 4;

    typedef enum logic {
        CH_A = 1'b0,
        CH_B = 1'b1
    } ch_sel_t;

endpackage

// File: rtl/demux_chan_fifo.sv
// rtl/demux_chan_fifo.sv - one demux channel buffer with a registered head word
module demux_chan_fifo
    import nibble_demux_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [DATA_W-1:0]          din,
    input  logic                       pop,
    output logic [DATA_W-1:0]          dout,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       full,
    output logic                       empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [LVL_W-1:0]  r_level;
    logic [DATA_W-1:0] r_head;

    logic              w_push;
    logic              w_pop;
    logic [PTR_W-1:0]  w_rd_next;

    assign full      = (r_level == LVL_W'(DEPTH));
    assign empty     = (r_level == '0);
    assign w_push    = push && !full;
    assign w_pop     = pop && !empty;
    assign w_rd_next = PTR_W'(r_rd_ptr + 1'b1);

    assign dout  = r_head;
    assign level = r_level;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_head   <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= din;
                r_wr_ptr        <= PTR_W'(r_wr_ptr + 1'b1);
            end
            if (w_pop) begin
                r_rd_ptr <= w_rd_next;
            end

            case ({w_push, w_pop})
                2'b10:   r_level <= LVL_W'(r_level + 1'b1);
                2'b01:   r_level <= LVL_W'(r_level - 1'b1);
                default: r_level <= r_level;
            endcase

            // Head tracks what will sit at the read pointer after this edge,
            // so a word written into an empty channel is visible next cycle.
            if (w_pop) begin
                if (r_level >= LVL_W'(2)) begin
                    r_head <= r_mem[w_rd_next];
                end else if (w_push) begin
                    r_head <= din;
                end
            end else if (w_push && empty) begin
                r_head <= din;
            end
        end
    end

endmodule

// File: rtl/nibble_demux.sv
// rtl/nibble_demux.sv - routes an input word stream into two independent buffered channels
module nibble_demux
    import nibble_demux_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [DATA_W-1:0]      q,
    input  logic                   q_valid,
    input  logic                   q_sel,
    output logic                   q_ready,
    output logic [DATA_W-1:0]      a,
    output logic                   fa,
    input  logic                   a_ready,
    output logic [DATA_W-1:0]      b,
    output logic                   fb,
    input  logic                   b_ready,
    output logic [$clog2(DEPTH):0] a_level,
    output logic [$clog2(DEPTH):0] b_level,
    output logic                   ovf
);

    ch_sel_t w_sel;
    logic    w_full_a;
    logic    w_full_b;
    logic    w_empty_a;
    logic    w_empty_b;
    logic    w_push_a;
    logic    w_push_b;
    logic    w_pop_a;
    logic    w_pop_b;
    logic    r_ovf;

    assign w_sel    = ch_sel_t'(q_sel);
    // Readiness comes only from registered occupancy, never from the consumers.
    assign q_ready  = (w_sel == CH_B) ? !w_full_b : !w_full_a;
    assign w_push_a = q_valid && q_ready && (w_sel == CH_A);
    assign w_push_b = q_valid && q_ready && (w_sel == CH_B);
    assign w_pop_a  = a_ready && !w_empty_a;
    assign w_pop_b  = b_ready && !w_empty_b;

    assign fa  = !w_empty_a;
    assign fb  = !w_empty_b;
    assign ovf = r_ovf;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (q_valid && !q_ready) begin
            r_ovf <= 1'b1;
        end
    end

    demux_chan_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_chan_a (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push_a),
        .din   (q),
        .pop   (w_pop_a),
        .dout  (a),
        .level (a_level),
        .full  (w_full_a),
        .empty (w_empty_a)
    );

    demux_chan_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_chan_b (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push_b),
        .din   (q),
        .pop   (w_pop_b),
        .dout  (b),
        .level (b_level),
        .full  (w_full_b),
        .empty (w_empty_b)
    );

endmodule

// File: tb/tb_nibble_demux.sv
// tb/tb_nibble_demux.sv - directed and random checks of nibble_demux against a queue model
module tb_nibble_demux;

    localparam int DW    = 4;
    localparam int DEPTH = 4;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] q;
    logic          q_valid;
    logic          q_sel;
    logic          q_ready;
    logic [DW-1:0] a;
    logic          fa;
    logic          a_ready;
    logic [DW-1:0] b;
    logic          fb;
    logic          b_ready;
    logic [LW-1:0] a_level;
    logic [LW-1:0] b_level;
    logic          ovf;

    int tests = 0;
    int fails = 0;

    logic [DW-1:0] qa [$];
    logic [DW-1:0] qb [$];
    logic          m_ovf;

    always #5 clk = ~clk;

    nibble_demux #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
        .clk     (clk),
        .rst     (rst),
        .q       (q),
        .q_valid (q_valid),
        .q_sel   (q_sel),
        .q_ready (q_ready),
        .a       (a),
        .fa      (fa),
        .a_ready (a_ready),
        .b       (b),
        .fb      (fb),
        .b_ready (b_ready),
        .a_level (a_level),
        .b_level (b_level),
        .ovf     (ovf)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        chk("a_level", 32'(a_level), 32'(qa.size()));
        chk("b_level", 32'(b_level), 32'(qb.size()));
        chk("fa", 32'(fa), 32'(qa.size() != 0));
        chk("fb", 32'(fb), 32'(qb.size() != 0));
        chk("ovf", 32'(ovf), 32'(m_ovf));
        if (qa.size() != 0) chk("a_head", 32'(a), 32'(qa[0]));
        if (qb.size() != 0) chk("b_head", 32'(b), 32'(qb[0]));
    endtask

    // One clock: drive, check readiness mid-cycle, advance, apply the model, check outputs.
    task automatic cycle(input logic v, input logic sel, input logic [DW-1:0] d,
                         input logic ar, input logic br, input logic r = 1'b0);
        bit sel_full;
        rst     = r;
        q_valid = v;
        q_sel   = sel;
        q       = d;
        a_ready = ar;
        b_ready = br;
        #1;
        sel_full = sel ? (qb.size() == DEPTH) : (qa.size() == DEPTH);
        if (!r) chk("q_ready", 32'(q_ready), 32'(!sel_full));
        @(posedge clk);
        if (r) begin
            qa.delete();
            qb.delete();
            m_ovf = 1'b0;
        end else begin
            if (ar && qa.size() != 0) void'(qa.pop_front());
            if (br && qb.size() != 0) void'(qb.pop_front());
            if (v && sel_full) m_ovf = 1'b1;
            if (v && !sel_full) begin
                if (sel) qb.push_back(d);
                else     qa.push_back(d);
            end
        end
        #1;
        check_outputs();
    endtask

    task automatic do_reset();
        cycle(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
        chk("rst_a", 32'(a), 32'h0);
        chk("rst_b", 32'(b), 32'h0);
    endtask

    initial begin
        rst = 1'b1; q = '0; q_valid = 1'b0; q_sel = 1'b0; a_ready = 1'b0; b_ready = 1'b0;
        m_ovf = 1'b0;
        @(posedge clk);
        #1;
        do_reset();

        // First word to A appears next cycle
        cycle(1'b1, 1'b0, 4'h4, 1'b0, 1'b0);
        chk("first_a", 32'(a), 32'h4);
        chk("first_fa", 32'(fa), 32'h1);
        cycle(1'b0, 1'b0, '0, 1'b1, 1'b0);

        // Two to B, one to A, then drain B in order
        cycle(1'b1, 1'b1, 4'hF, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 4'h5, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 4'hC, 1'b0, 1'b0);
        chk("b_lvl2", 32'(b_level), 32'd2);
        chk("a_lvl1", 32'(a_level), 32'd1);
        chk("b_first", 32'(b), 32'hF);
        cycle(1'b0, 1'b0, '0, 1'b0, 1'b1);
        chk("b_second", 32'(b), 32'h5);
        cycle(1'b0, 1'b0, '0, 1'b0, 1'b1);
        chk("b_drained", 32'(fb), 32'h0);

        // Fill A, B stays writable, overflow on a fifth word
        cycle(1'b1, 1'b0, 4'h1, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 4'h2, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 4'h3, 1'b0, 1'b0);
        chk("a_full_lvl", 32'(a_level), 32'd4);
        cycle(1'b0, 1'b1, '0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 4'h9, 1'b0, 1'b0);
        chk("ovf_set", 32'(ovf), 32'h1);
        chk("a_stays4", 32'(a_level), 32'd4);

        // Full with pop: no push, level drops to 3
        cycle(1'b1, 1'b0, 4'h7, 1'b1, 1'b0);
        chk("full_pop_lvl", 32'(a_level), 32'd3);
        cycle(1'b0, 1'b0, '0, 1'b1, 1'b0);

        // Push and pop together across the pointer wrap
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, 1'b0, DW'(i + 3), 1'b1, 1'b0);
            chk("wrap_lvl", 32'(a_level), 32'd2);
        end

        // Reset with both channels at level 2
        cycle(1'b0, 1'b0, '0, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 4'hA, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 4'hB, 1'b0, 1'b0);
        chk("pre_rst_b", 32'(b_level), 32'd2);
        do_reset();
        cycle(1'b0, 1'b0, '0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, '0, 1'b0, 1'b0);

        // Random traffic, including occasional resets and empty-channel pops
        for (int i = 0; i < 600; i++) begin
            cycle(1'($urandom_range(0, 3) != 0), 1'($urandom), DW'($urandom),
                  1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1) == 0),
                  1'($urandom_range(0, 99) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout tests=%0d", tests);
        $fatal(1, "timeout");
    end

endmodule
